// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive framer fed by the synchroniser/edge-detect stage.
// The start-bit detect comes in as a falling-edge pulse. The FSM then times each
// bit with a baud counter and samples the line at mid-bit. Data arrives LSB first.
// A good stop bit produces a one-cycle data_valid strobe. A low stop bit produces
// a one-cycle frame_err strobe instead.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_fall,
  input  logic                 rx_level,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;

  // Counter value at which the start bit is re-checked.
  // The start edge is seen one cycle before the counter starts at 0.
  // So HALF-1 lands exactly at mid start bit.
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_reg,   state_next;
  logic [CNT_W-1:0]     cnt_reg,     cnt_next;
  logic [BIT_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg,   shift_next;
  logic [DATA_BITS-1:0] data_reg,    data_next;
  logic                 valid_reg,   valid_next;
  logic                 ferr_reg,    ferr_next;

  // State and datapath registers; reset abandons any frame in progress silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  // Next-state, bit timing and sampling decisions; strobes default low each cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        // Only the edge pulse starts a frame.
        // A line held low (break) therefore cannot retrigger.
        if (rx_fall) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      START: begin
        if (cnt_reg == CNT_HALF_M1) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          // A line already back high at mid start bit was a glitch.
          state_next   = rx_level ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          // Right shift means the first bit on the wire finishes in bit 0.
          shift_next = {rx_level, shift_reg[DATA_BITS-1:1]};
          cnt_next   = '0;
          if (bit_idx_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + BIT_ONE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          // Leave at mid stop bit so a back-to-back start edge is caught.
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_level) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign data_out   = data_reg;
  assign data_valid = valid_reg;
  assign frame_err  = ferr_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames against uart_rx_fsm with CLKS_PER_BIT=16, DATA_BITS=8.
// The bench derives rx_fall from the driven rx_level.
// Outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_fsm;

  localparam int N = 16;
  localparam int D = 8;
  localparam int HIST = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_fall = 1'b0;
  logic         rx_level = 1'b1;
  logic [D-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic         busy;

  uart_rx_fsm #(
    .CLKS_PER_BIT(N),
    .DATA_BITS   (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_fall   (rx_fall),
    .rx_level  (rx_level),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   checks_total  = 0;
  int   checks_passed = 0;
  int   cyc           = 0;
  int   dv_count      = 0;
  int   fe_count      = 0;
  logic both_seen     = 1'b0;
  logic prev_lvl      = 1'b1;

  logic         busy_hist [HIST];
  logic         dv_hist   [HIST];
  logic         fe_hist   [HIST];
  logic [D-1:0] data_hist [HIST];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Drive the line level for cycle cyc, then record the outputs of cycle cyc+1.
  task automatic tick(input logic lvl);
    int i;
    rx_level = lvl;
    rx_fall  = prev_lvl & ~lvl;
    prev_lvl = lvl;
    @(posedge clk);
    #1;
    cyc++;
    i = cyc % HIST;
    busy_hist[i] = busy;
    dv_hist[i]   = data_valid;
    fe_hist[i]   = frame_err;
    data_hist[i] = data_out;
    if (data_valid && frame_err) both_seen = 1'b1;
    if (data_valid) begin
      dv_count++;
      $display("cycle %0d: data_valid data_out=0x%02h", cyc, data_out);
    end
    if (frame_err) begin
      fe_count++;
      $display("cycle %0d: frame_err data_out=0x%02h", cyc, data_out);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, output int t_start);
    logic [7:0] bv;
    bv = b;
    t_start = cyc;
    repeat (N) tick(1'b0);
    for (int k = 0; k < D; k++) begin
      repeat (N) tick(bv[k]);
    end
    repeat (N) tick(stop_lvl);
  endtask

  function automatic int hi(input int c);
    return c % HIST;
  endfunction

  // Expect one good byte with the strobe exactly at T+153.
  task automatic check_good(input string tag, input int t, input logic [7:0] exp);
    check({tag, " dv_before"}, 32'(dv_hist[hi(t + 152)]), 32'd0);
    check({tag, " dv_at"},     32'(dv_hist[hi(t + 153)]), 32'd1);
    check({tag, " data"},      32'(data_hist[hi(t + 153)]), 32'(exp));
    check({tag, " dv_after"},  32'(dv_hist[hi(t + 154)]), 32'd0);
    check({tag, " fe"},        32'(fe_hist[hi(t + 153)]), 32'd0);
  endtask

  initial begin
    int t, t2, dv0, fe0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset dv", 32'(data_valid), 32'd0);
    check("reset fe", 32'(frame_err), 32'd0);
    rst = 1'b0;
    idle(5);

    // Load a nonzero byte, then assert reset between clock edges while idle.
    send_frame(8'h96, 1'b1, t);
    idle(4);
    check("pre-reset data_out", 32'(data_out), 32'h96);
    rst = 1'b1;
    #2;
    check("async reset data_out", 32'(data_out), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(5);

    // Good frame 0xA5 with exact timing.
    dv0 = dv_count;
    send_frame(8'hA5, 1'b1, t);
    idle(10);
    check("a5 busy T", 32'(busy_hist[hi(t)]), 32'd0);
    check("a5 busy T+1", 32'(busy_hist[hi(t + 1)]), 32'd1);
    check("a5 busy T+152", 32'(busy_hist[hi(t + 152)]), 32'd1);
    check("a5 busy T+153", 32'(busy_hist[hi(t + 153)]), 32'd0);
    check_good("a5", t, 8'hA5);
    check("a5 dv count", 32'(dv_count - dv0), 32'd1);

    // Glitch: four low cycles, then high.
    dv0 = dv_count;
    fe0 = fe_count;
    t = cyc;
    repeat (4) tick(1'b0);
    idle(30);
    check("glitch busy T+1", 32'(busy_hist[hi(t + 1)]), 32'd1);
    check("glitch busy T+8", 32'(busy_hist[hi(t + 8)]), 32'd1);
    check("glitch busy T+9", 32'(busy_hist[hi(t + 9)]), 32'd0);
    check("glitch no dv", 32'(dv_count - dv0), 32'd0);
    check("glitch no fe", 32'(fe_count - fe0), 32'd0);
    check("glitch data_out", 32'(data_out), 32'hA5);

    // Framing error: 0x3C with a low stop bit.
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, t);
    idle(10);
    check("ferr fe T+152", 32'(fe_hist[hi(t + 152)]), 32'd0);
    check("ferr fe T+153", 32'(fe_hist[hi(t + 153)]), 32'd1);
    check("ferr fe T+154", 32'(fe_hist[hi(t + 154)]), 32'd0);
    check("ferr dv", 32'(dv_count - dv0), 32'd0);
    check("ferr fe count", 32'(fe_count - fe0), 32'd1);
    check("ferr data_out", 32'(data_hist[hi(t + 153)]), 32'hA5);

    // Back-to-back: 0x00, then 0xFF with no idle gap.
    dv0 = dv_count;
    send_frame(8'h00, 1'b1, t);
    send_frame(8'hFF, 1'b1, t2);
    idle(10);
    check("b2b gap", 32'(t2 - t), 32'd160);
    check_good("b2b first", t, 8'h00);
    check_good("b2b second", t2, 8'hFF);
    check("b2b dv count", 32'(dv_count - dv0), 32'd2);

    // Reset during bit 3 of 0xC3, then a clean frame 0x5A.
    dv0 = dv_count;
    fe0 = fe_count;
    repeat (N) tick(1'b0);
    tick(1'b1);
    repeat (N - 1) tick(1'b1);
    repeat (N) tick(1'b1);
    repeat (N) tick(1'b0);
    repeat (4) tick(1'b0);
    check("midframe busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    check("midframe async busy", 32'(busy), 32'd0);
    repeat (4) tick(1'b0);
    idle(4);
    rst = 1'b0;
    idle(N * 12);
    check("midframe busy after", 32'(busy), 32'd0);
    check("midframe no dv", 32'(dv_count - dv0), 32'd0);
    check("midframe no fe", 32'(fe_count - fe0), 32'd0);
    send_frame(8'h5A, 1'b1, t);
    idle(10);
    check_good("5a", t, 8'h5A);
    check("5a data_out hold", 32'(data_out), 32'h5A);

    check("strobes never together", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
